// File: rtl/systolic_arbiter.sv
// rtl/systolic_arbiter.sv - round-robin sharing of one systolic array between two block requesters
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0, req1            block requests, sampled only while idle
//   a0, b0, a1, b1        per-requester operand blocks (element 0 in the LSBs)
//   gnt0, gnt1            array ownership, one-hot or zero
//   done0, done1          one-cycle completion pulse for the owning requester
//   result                captured array result, held until the next capture
//   arr_load, arr_start   array load pulse and start window
//   arr_block_a/b         operands routed to the array from the owner
//   arr_result            result block returned by the array
//   busy                  high whenever a transaction is in flight
module systolic_arbiter #(
   parameter int DATA_W  = 16,
   parameter int J       = 2,
   parameter int K       = 2,
   parameter int MUL_LAT = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req0,
   input  logic                    req1,
   input  logic [J*K*DATA_W-1:0]   a0,
   input  logic [J*K*DATA_W-1:0]   b0,
   input  logic [J*K*DATA_W-1:0]   a1,
   input  logic [J*K*DATA_W-1:0]   b1,
   output logic                    gnt0,
   output logic                    gnt1,
   output logic                    done0,
   output logic                    done1,
   output logic [J*K*DATA_W-1:0]   result,
   output logic                    arr_load,
   output logic                    arr_start,
   output logic [J*K*DATA_W-1:0]   arr_block_a,
   output logic [J*K*DATA_W-1:0]   arr_block_b,
   input  logic [J*K*DATA_W-1:0]   arr_result,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RUN     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MUL_LAT - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       last, last_nxt;
   logic       gnt0_nxt, gnt1_nxt;
   logic       done0_nxt, done1_nxt;
   logic       load_nxt, start_nxt;
   logic       capture;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      gnt0_nxt  = gnt0;
      gnt1_nxt  = gnt1;
      done0_nxt = 1'b0;
      done1_nxt = 1'b0;
      load_nxt  = 1'b0;
      start_nxt = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            // last==1 means requester 1 was served most recently, so 0 wins a tie
            if (req0 && (!req1 || last)) begin
               gnt0_nxt  = 1'b1;
               load_nxt  = 1'b1;
               state_nxt = LOAD;
            end else if (req1) begin
               gnt1_nxt  = 1'b1;
               load_nxt  = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            cnt_nxt   = 8'd0;
            start_nxt = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            cnt_nxt = cnt + 8'd1;
            if (cnt == CNT_LAST) begin
               capture   = 1'b1;
               done0_nxt = gnt0;
               done1_nxt = gnt1;
               last_nxt  = gnt1;
               state_nxt = RELEASE;
            end else begin
               start_nxt = 1'b1;
            end
         end
         RELEASE: begin
            gnt0_nxt  = 1'b0;
            gnt1_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         last      <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         arr_load  <= 1'b0;
         arr_start <= 1'b0;
         result    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         gnt0      <= gnt0_nxt;
         gnt1      <= gnt1_nxt;
         done0     <= done0_nxt;
         done1     <= done1_nxt;
         arr_load  <= load_nxt;
         arr_start <= start_nxt;
         if (capture) begin
            result <= arr_result;
         end
      end
   end

   // Operands follow the registered grant, so they are steady for the whole transaction
   assign arr_block_a = gnt0 ? a0 : (gnt1 ? a1 : '0);
   assign arr_block_b = gnt0 ? b0 : (gnt1 ? b1 : '0);
   assign busy        = (state != IDLE);

endmodule
